// File: rtl/rotor_step_back_if.sv
// Request/position bundle between the key controller and the reverse rotor stepper.
// master = key controller side, slave = stepping engine.
interface rotor_step_back_if #(
  parameter int NUM_ROTORS = 3,
  parameter int POS_W      = 5,
  parameter int CNT_W      = 8
);
  logic                          load;
  logic [NUM_ROTORS*POS_W-1:0]   load_pos;
  logic                          req_valid;
  logic [CNT_W-1:0]              req_count;
  logic                          req_ready;
  logic                          busy;
  logic                          step_pulse;
  logic                          done;
  logic [NUM_ROTORS*POS_W-1:0]   pos;

  modport master (
    output load, load_pos, req_valid, req_count,
    input  req_ready, busy, step_pulse, done, pos
  );

  modport slave (
    input  load, load_pos, req_valid, req_count,
    output req_ready, busy, step_pulse, done, pos
  );
endinterface

// File: rtl/rotor_step_back.sv
// Reverse rotor-stepping engine: walks the rotor position chain backward one keystroke
// per clock, borrowing into the next rotor when the faster one lands on its notch.
module rotor_step_back #(
  parameter int                          NUM_ROTORS = 3,
  parameter int                          POS_W      = 5,
  parameter int                          MODULUS    = 26,
  parameter logic [NUM_ROTORS*POS_W-1:0] NOTCH      = {5'd21, 5'd4, 5'd16},
  parameter int                          CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rotor_step_back_if.slave   bus
);

  localparam logic [POS_W-1:0] MAX_POS = POS_W'(MODULUS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [NUM_ROTORS*POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0]            remaining_q, remaining_d;

  logic [NUM_ROTORS*POS_W-1:0] stepPos;
  logic [NUM_ROTORS*POS_W-1:0] loadClean;
  logic                        borrow;
  logic                        reqReady;
  logic                        busyOut;
  logic                        stepPulse;
  logic                        doneOut;

  // One backward keystroke: a rotor borrows from the next only when its new value is its notch.
  always_comb begin
    stepPos = pos_q;
    borrow  = 1'b1;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (borrow) begin
        if (pos_q[i*POS_W +: POS_W] == '0) begin
          stepPos[i*POS_W +: POS_W] = MAX_POS;
        end else begin
          stepPos[i*POS_W +: POS_W] = pos_q[i*POS_W +: POS_W] - POS_W'(1);
        end
      end
      borrow = borrow && (stepPos[i*POS_W +: POS_W] == NOTCH[i*POS_W +: POS_W]);
    end
  end

  always_comb begin
    loadClean = bus.load_pos;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (bus.load_pos[i*POS_W +: POS_W] > MAX_POS) begin
        loadClean[i*POS_W +: POS_W] = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    remaining_d = remaining_q;
    reqReady    = 1'b0;
    busyOut     = 1'b0;
    stepPulse   = 1'b0;
    doneOut     = 1'b0;
    case (state_q)
      IDLE: begin
        reqReady = ~bus.load;
        // A load takes precedence and swallows any request presented in the same cycle.
        if (bus.load) begin
          pos_d = loadClean;
        end else if (bus.req_valid) begin
          remaining_d = bus.req_count;
          state_d     = (bus.req_count != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busyOut     = 1'b1;
        stepPulse   = 1'b1;
        pos_d       = stepPos;
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        doneOut = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      remaining_q <= remaining_d;
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.busy       = busyOut;
  assign bus.step_pulse = stepPulse;
  assign bus.done       = doneOut;
  assign bus.pos        = pos_q;

endmodule
